// File: rtl/dmac_pkg.sv
// Shared state encoding and default sizing for the DMAC channel arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmac_pkg;

  localparam int DMAC_NUM_CH  = 4;
  localparam int DMAC_QUOTA_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dmac_rr_picker.sv
// Picks one requesting channel: highest index (fixed) or first at/after ptr (round-robin).
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid simply reflects whether any request is present.
module dmac_rr_picker #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  input  logic                      rr_mode,
  output logic                      valid,
  output logic [$clog2(NUM_CH)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan candidates in priority order; the sum is one bit wider so the wrap works for any NUM_CH.
  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    if (rr_mode) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NUM_CH)) begin
          sum = sum - (IDX_W+1)'(NUM_CH);
        end
        cand = sum[IDX_W-1:0];
        if (!found && req[cand]) begin
          found = 1'b1;
          idx   = cand;
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (req[k]) begin
          idx = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/dmac_chan_arbiter.sv
// Arbitrates peripheral DMA requests onto one AHB master tenure with optional beat quota.
// Latency: 1 clk DmacReq->Bus_Req; Bus_Grant->Channel_en 1 clk; ch_done->ReqAck 1 clk.
// Backpressure: Bus_Grant low holds the channel in REQ (counter kept) until re-granted.
module dmac_chan_arbiter
  import dmac_pkg::*;
#(
  parameter int NUM_CH  = DMAC_NUM_CH,
  parameter int QUOTA_W = DMAC_QUOTA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         DmacReq,
  input  logic                      rr_mode,
  input  logic [QUOTA_W-1:0]        quota,
  input  logic                      Bus_Grant,
  input  logic                      beat_done,
  input  logic                      ch_done,
  output logic                      Bus_Req,
  output logic [NUM_CH-1:0]         Channel_en,
  output logic [NUM_CH-1:0]         ReqAck,
  output logic [$clog2(NUM_CH)-1:0] active_ch,
  output logic                      busy
);

  localparam int               IDX_W    = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   active_ch_q, active_ch_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [QUOTA_W-1:0] cnt_q, cnt_d;
  logic               bus_req_q, bus_req_d;
  logic [NUM_CH-1:0]  chan_en_q, chan_en_d;
  logic [NUM_CH-1:0]  req_ack_q, req_ack_d;
  logic               busy_q, busy_d;

  logic [NUM_CH-1:0]  cur_oh;
  logic [NUM_CH-1:0]  nxt_oh;
  logic [NUM_CH-1:0]  pick_req;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_after_pick;
  logic               other_pending;
  logic               quota_hit;

  // One-hot of the latched channel; during a tenure it is masked out of re-arbitration.
  always_comb begin
    cur_oh              = '0;
    cur_oh[active_ch_q] = 1'b1;
    other_pending       = |(DmacReq & ~cur_oh);
    pick_req            = (state_q == ACTIVE) ? (DmacReq & ~cur_oh) : DmacReq;
  end

  dmac_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req     (pick_req),
    .ptr     (rr_ptr_q),
    .rr_mode (rr_mode),
    .valid   (pick_vld),
    .idx     (pick_idx)
  );

  // Round-robin pointer advances to the slot after whichever channel is latched.
  always_comb begin
    ptr_after_pick = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
    quota_hit      = (quota != '0) && beat_done && (cnt_q == (quota - QUOTA_W'(1)));
  end

  // Next-state, winner latch and beat counter; ch_done outranks quota expiry and grant loss.
  always_comb begin
    state_d     = state_q;
    active_ch_d = active_ch_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          active_ch_d = pick_idx;
          rr_ptr_d    = ptr_after_pick;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (Bus_Grant) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ch_done) begin
          state_d = DONE;
        end else if (quota_hit && other_pending) begin
          active_ch_d = pick_idx;
          rr_ptr_d    = ptr_after_pick;
          cnt_d       = '0;
          state_d     = REQ;
        end else begin
          if (quota_hit) begin
            cnt_d = '0;
          end else if (beat_done) begin
            cnt_d = cnt_q + QUOTA_W'(1);
          end
          if (!Bus_Grant) begin
            state_d = REQ;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so they leave straight from flops.
  always_comb begin
    nxt_oh              = '0;
    nxt_oh[active_ch_d] = 1'b1;
    bus_req_d           = (state_d == REQ) || (state_d == ACTIVE);
    chan_en_d           = (state_d == ACTIVE) ? nxt_oh : '0;
    req_ack_d           = (state_d == DONE) ? nxt_oh : '0;
    busy_d              = (state_d != IDLE);
  end

  // All arbiter state; reset abandons any tenure without acknowledging it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      active_ch_q <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      chan_en_q   <= '0;
      req_ack_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_ch_q <= active_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      chan_en_q   <= chan_en_d;
      req_ack_q   <= req_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign Bus_Req    = bus_req_q;
  assign Channel_en = chan_en_q;
  assign ReqAck     = req_ack_q;
  assign active_ch  = active_ch_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmac_chan_arbiter.sv
// Directed bench for the DMAC channel arbiter with hand-computed expectations.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next.
// Backpressure: Bus_Grant is toggled directly by the scenarios.
module tb_dmac_chan_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] DmacReq;
  logic       rr_mode;
  logic [3:0] quota;
  logic       Bus_Grant;
  logic       beat_done;
  logic       ch_done;
  logic       Bus_Req;
  logic [3:0] Channel_en;
  logic [3:0] ReqAck;
  logic [1:0] active_ch;
  logic       busy;

  int checks;
  int errors;

  dmac_chan_arbiter #(
    .NUM_CH  (4),
    .QUOTA_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .DmacReq    (DmacReq),
    .rr_mode    (rr_mode),
    .quota      (quota),
    .Bus_Grant  (Bus_Grant),
    .beat_done  (beat_done),
    .ch_done    (ch_done),
    .Bus_Req    (Bus_Req),
    .Channel_en (Channel_en),
    .ReqAck     (ReqAck),
    .active_ch  (active_ch),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; DmacReq = '0; rr_mode = 1'b0; quota = '0;
    Bus_Grant = 1'b0; beat_done = 1'b0; ch_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; DmacReq = 4'b1111; rr_mode = 1'b0; quota = '0;
    Bus_Grant = 1'b1; beat_done = 1'b0; ch_done = 1'b0;
    tick();
    checks++; if (Bus_Req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", Bus_Req); end
    checks++; if (Channel_en !== 4'b0000) begin errors++; $display("FAIL reset_chan_en: got %b want 0000", Channel_en); end
    checks++; if (ReqAck !== 4'b0000) begin errors++; $display("FAIL reset_reqack: got %b want 0000", ReqAck); end
    checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active_ch: got %0d want 0", active_ch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    rr_mode = 1'b0; Bus_Grant = 1'b1; DmacReq = 4'b0110;
    tick();
    checks++; if (active_ch !== 2'd2) begin errors++; $display("FAIL fixed_winner: got %0d want 2", active_ch); end
    checks++; if (Bus_Req !== 1'b1 || busy !== 1'b1 || Channel_en !== 4'b0000) begin errors++; $display("FAIL fixed_req_state: bus_req=%b busy=%b en=%b want 1 1 0000", Bus_Req, busy, Channel_en); end
    tick();
    checks++; if (Channel_en !== 4'b0100) begin errors++; $display("FAIL fixed_chan_en: got %b want 0100", Channel_en); end
    ch_done = 1'b1; DmacReq = 4'b0010;
    tick();
    ch_done = 1'b0;
    checks++; if (ReqAck !== 4'b0100 || Bus_Req !== 1'b0 || Channel_en !== 4'b0000) begin errors++; $display("FAIL fixed_done: ack=%b bus_req=%b en=%b want 0100 0 0000", ReqAck, Bus_Req, Channel_en); end
    tick();
    checks++; if (ReqAck !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL fixed_ack_pulse: ack=%b busy=%b want 0000 0", ReqAck, busy); end
    tick();
    checks++; if (active_ch !== 2'd1) begin errors++; $display("FAIL fixed_second_winner: got %0d want 1", active_ch); end
    tick();
    checks++; if (Channel_en !== 4'b0010) begin errors++; $display("FAIL fixed_second_en: got %b want 0010", Channel_en); end
  endtask

  task automatic test_round_robin();
    do_reset();
    rr_mode = 1'b0;
    tick();
    rr_mode = 1'b1; Bus_Grant = 1'b1; DmacReq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_ch;
      logic [3:0] exp_oh;
      exp_ch = 2'(i % 4);
      exp_oh = 4'b0001 << exp_ch;
      tick();
      checks++; if (active_ch !== exp_ch) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, active_ch, exp_ch); end
      tick();
      checks++; if (Channel_en !== exp_oh) begin errors++; $display("FAIL rr_chan_en[%0d]: got %b want %b", i, Channel_en, exp_oh); end
      ch_done = 1'b1;
      tick();
      ch_done = 1'b0;
      checks++; if (ReqAck !== exp_oh) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", i, ReqAck, exp_oh); end
      tick();
    end
  endtask

  task automatic test_quota_preempt();
    do_reset();
    rr_mode = 1'b1; quota = 4'd3; Bus_Grant = 1'b1; DmacReq = 4'b0011;
    tick();
    checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL quota_first: got %0d want 0", active_ch); end
    tick();
    beat_done = 1'b1;
    for (int b = 0; b < 2; b++) begin
      tick();
      checks++; if (Channel_en !== 4'b0001) begin errors++; $display("FAIL quota_beat[%0d]: en=%b want 0001", b, Channel_en); end
    end
    tick();
    beat_done = 1'b0;
    checks++; if (Bus_Req !== 1'b1 || Channel_en !== 4'b0000 || active_ch !== 2'd1 || ReqAck !== 4'b0000) begin errors++; $display("FAIL quota_switch: bus_req=%b en=%b ch=%0d ack=%b want 1 0000 1 0000", Bus_Req, Channel_en, active_ch, ReqAck); end
    tick();
    checks++; if (Channel_en !== 4'b0010 || ReqAck !== 4'b0000) begin errors++; $display("FAIL quota_new_en: en=%b ack=%b want 0010 0000", Channel_en, ReqAck); end
    // Lone requester: expiry keeps the tenure and wraps the counter.
    DmacReq = 4'b0010; beat_done = 1'b1;
    tick(); tick(); tick();
    checks++; if (Channel_en !== 4'b0010 || Bus_Req !== 1'b1) begin errors++; $display("FAIL quota_alone_stay: en=%b bus_req=%b want 0010 1", Channel_en, Bus_Req); end
    DmacReq = 4'b0011;
    tick(); tick();
    checks++; if (Channel_en !== 4'b0010) begin errors++; $display("FAIL quota_wrap_count: en=%b want 0010", Channel_en); end
    tick();
    beat_done = 1'b0;
    checks++; if (active_ch !== 2'd0 || Channel_en !== 4'b0000 || Bus_Req !== 1'b1) begin errors++; $display("FAIL quota_wrap_expire: ch=%0d en=%b bus_req=%b want 0 0000 1", active_ch, Channel_en, Bus_Req); end
  endtask

  task automatic test_grant_loss();
    do_reset();
    rr_mode = 1'b1; quota = 4'd4; Bus_Grant = 1'b1; DmacReq = 4'b0001;
    tick(); tick();
    beat_done = 1'b1;
    tick(); tick();
    beat_done = 1'b0; Bus_Grant = 1'b0;
    tick();
    checks++; if (Channel_en !== 4'b0000 || Bus_Req !== 1'b1 || busy !== 1'b1 || active_ch !== 2'd0) begin errors++; $display("FAIL grant_loss: en=%b bus_req=%b busy=%b ch=%0d want 0000 1 1 0", Channel_en, Bus_Req, busy, active_ch); end
    tick();
    checks++; if (Channel_en !== 4'b0000 || Bus_Req !== 1'b1) begin errors++; $display("FAIL grant_wait: en=%b bus_req=%b want 0000 1", Channel_en, Bus_Req); end
    Bus_Grant = 1'b1; DmacReq = 4'b0011;
    tick();
    checks++; if (Channel_en !== 4'b0001) begin errors++; $display("FAIL grant_regrant: en=%b want 0001", Channel_en); end
    beat_done = 1'b1;
    tick();
    checks++; if (Channel_en !== 4'b0001) begin errors++; $display("FAIL grant_beat3: en=%b want 0001", Channel_en); end
    tick();
    beat_done = 1'b0;
    checks++; if (active_ch !== 2'd1 || Channel_en !== 4'b0000 || ReqAck !== 4'b0000) begin errors++; $display("FAIL grant_expire: ch=%0d en=%b ack=%b want 1 0000 0000", active_ch, Channel_en, ReqAck); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    rr_mode = 1'b1; quota = 4'd2; Bus_Grant = 1'b1; DmacReq = 4'b0011;
    tick(); tick();
    beat_done = 1'b1;
    tick();
    ch_done = 1'b1;
    tick();
    beat_done = 1'b0; ch_done = 1'b0; DmacReq = 4'b0010;
    checks++; if (ReqAck !== 4'b0001 || Bus_Req !== 1'b0 || active_ch !== 2'd0) begin errors++; $display("FAIL simul_done: ack=%b bus_req=%b ch=%0d want 0001 0 0", ReqAck, Bus_Req, active_ch); end
    tick();
    checks++; if (ReqAck !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL simul_idle: ack=%b busy=%b want 0000 0", ReqAck, busy); end
    tick();
    checks++; if (active_ch !== 2'd1 || Bus_Req !== 1'b1) begin errors++; $display("FAIL simul_next: ch=%0d bus_req=%b want 1 1", active_ch, Bus_Req); end
  endtask

  task automatic test_reset_mid_tenure();
    do_reset();
    rr_mode = 1'b1; Bus_Grant = 1'b1; DmacReq = 4'b0010;
    tick();
    checks++; if (active_ch !== 2'd1) begin errors++; $display("FAIL midrst_winner: got %0d want 1", active_ch); end
    tick();
    checks++; if (Channel_en !== 4'b0010) begin errors++; $display("FAIL midrst_active: en=%b want 0010", Channel_en); end
    rst = 1'b1; ch_done = 1'b1;
    tick();
    rst = 1'b0; ch_done = 1'b0; DmacReq = 4'b1111;
    checks++; if (Bus_Req !== 1'b0 || Channel_en !== 4'b0000 || ReqAck !== 4'b0000 || busy !== 1'b0 || active_ch !== 2'd0) begin errors++; $display("FAIL midrst_outputs: bus_req=%b en=%b ack=%b busy=%b ch=%0d want all 0", Bus_Req, Channel_en, ReqAck, busy, active_ch); end
    tick();
    checks++; if (active_ch !== 2'd0 || ReqAck !== 4'b0000 || Bus_Req !== 1'b1) begin errors++; $display("FAIL midrst_ptr: ch=%0d ack=%b bus_req=%b want 0 0000 1", active_ch, ReqAck, Bus_Req); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_quota_preempt();
    test_grant_loss();
    test_simultaneous();
    test_reset_mid_tenure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
